alu_arb2: RTL and testbench

ALU_ARB2 -- requirements
Module: alu_arb2

---
 rtl/alu_arb2.sv | 132 +++++++++++++
 tb/tb_alu_arb2.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb2.sv
// rtl/alu_arb2.sv - two-requester round-robin front end for one shared combinational ALU
module alu_arb2 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_src1_0,
  input  logic [31:0]      req_src2_0,
  input  logic [31:0]      req_src1_1,
  input  logic [31:0]      req_src2_1,
  input  logic [3:0]       req_ctrl_0,
  input  logic [3:0]       req_ctrl_1,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result_0,
  output logic [31:0]      rsp_result_1,
  output logic [2:0]       rsp_flags_0,
  output logic [2:0]       rsp_flags_1,
  output logic [CNT_W-1:0] op_cnt
);

  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]      result_0_q, result_0_d;
  logic [31:0]      result_1_q, result_1_d;
  logic [2:0]       flags_0_q, flags_0_d;
  logic [2:0]       flags_1_q, flags_1_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [2:0]       alu_flags;

  assign alu_flags = {alu_overflow, alu_cout, alu_zero};

  // Arbitration: a slot may accept only if empty or draining; ties go away from last_grant.
  // Gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    elig  = req_valid & (~rsp_valid_q | rsp_ready) & {2{rst_n}};
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Steer the granted requester onto the shared ALU; idle bus is all zero.
  always_comb begin
    alu_src1 = 32'd0;
    alu_src2 = 32'd0;
    alu_ctrl = 4'd0;
    if (grant[0]) begin
      alu_src1 = req_src1_0;
      alu_src2 = req_src2_0;
      alu_ctrl = req_ctrl_0;
    end else if (grant[1]) begin
      alu_src1 = req_src1_1;
      alu_src2 = req_src2_1;
      alu_ctrl = req_ctrl_1;
    end
  end

  // Next state: a grant loads its slot (even while draining), otherwise a handshake empties it.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    result_0_d   = result_0_q;
    result_1_d   = result_1_q;
    flags_0_d    = flags_0_q;
    flags_1_d    = flags_1_q;
    last_grant_d = last_grant_q;
    op_cnt_d     = op_cnt_q;
    if (grant[0]) begin
      result_0_d     = alu_result;
      flags_0_d      = alu_flags;
      rsp_valid_d[0] = 1'b1;
      last_grant_d   = 1'b0;
    end else if (rsp_valid_q[0] && rsp_ready[0]) begin
      rsp_valid_d[0] = 1'b0;
    end
    if (grant[1]) begin
      result_1_d     = alu_result;
      flags_1_d      = alu_flags;
      rsp_valid_d[1] = 1'b1;
      last_grant_d   = 1'b1;
    end else if (rsp_valid_q[1] && rsp_ready[1]) begin
      rsp_valid_d[1] = 1'b0;
    end
    if ((grant != 2'b00) && (op_cnt_q != {CNT_W{1'b1}})) begin
      op_cnt_d = op_cnt_q + CNT_W'(1);
    end
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 2'b00;
      result_0_q   <= 32'd0;
      result_1_q   <= 32'd0;
      flags_0_q    <= 3'd0;
      flags_1_q    <= 3'd0;
      op_cnt_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      result_0_q   <= result_0_d;
      result_1_q   <= result_1_d;
      flags_0_q    <= flags_0_d;
      flags_1_q    <= flags_1_d;
      op_cnt_q     <= op_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result_0 = result_0_q;
  assign rsp_result_1 = result_1_q;
  assign rsp_flags_0  = flags_0_q;
  assign rsp_flags_1  = flags_1_q;
  assign op_cnt       = op_cnt_q;

endmodule

// File: tb/tb_alu_arb2.sv
// tb/tb_alu_arb2.sv - directed-vector bench for alu_arb2 with a behavioural ALU
module tb_alu_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_src1_0, req_src2_0, req_src1_1, req_src2_1;
  logic [3:0]  req_ctrl_0, req_ctrl_1;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result_0, rsp_result_1;
  logic [2:0]  rsp_flags_0, rsp_flags_1;
  logic [15:0] op_cnt;

  logic [1:0]  s_req_ready;
  logic [31:0] s_alu_src1, s_alu_src2;
  logic [3:0]  s_alu_ctrl;
  logic [1:0]  s_rsp_valid;
  logic [31:0] s_rsp_result_0, s_rsp_result_1;
  logic [2:0]  s_rsp_flags_0, s_rsp_flags_1;
  logic [3:0]  s_op_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int exp_cnt;
  logic [1:0] exp_g;

  always #5 clk = ~clk;

  alu_arb2 dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1_0(req_src1_0), .req_src2_0(req_src2_0),
    .req_src1_1(req_src1_1), .req_src2_1(req_src2_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
    .rsp_flags_0(rsp_flags_0), .rsp_flags_1(rsp_flags_1), .op_cnt(op_cnt)
  );

  // Narrow-counter copy sees identical stimulus; only its op_cnt is checked.
  alu_arb2 #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_src1_0(req_src1_0), .req_src2_0(req_src2_0),
    .req_src1_1(req_src1_1), .req_src2_1(req_src2_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .alu_src1(s_alu_src1), .alu_src2(s_alu_src2), .alu_ctrl(s_alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_0(s_rsp_result_0), .rsp_result_1(s_rsp_result_1),
    .rsp_flags_0(s_rsp_flags_0), .rsp_flags_1(s_rsp_flags_1), .op_cnt(s_op_cnt)
  );

  // Shared ALU: and/or/add/sub with zero, carry-out and signed overflow.
  always_comb begin
    logic [32:0] w;
    w = 33'd0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: w = {1'b0, alu_src1 & alu_src2};
      4'b0001: w = {1'b0, alu_src1 | alu_src2};
      4'b0010: begin
        w = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (w[31] != alu_src1[31]);
      end
      4'b0110: begin
        w = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (w[31] != alu_src1[31]);
      end
      default: w = 33'd0;
    endcase
    alu_result = w[31:0];
    alu_cout   = w[32];
    alu_zero   = (w[31:0] == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_src1_0 = 32'd5; req_src2_0 = 32'd3; req_ctrl_0 = 4'b0010;
    req_src1_1 = 32'd9; req_src2_1 = 32'd4; req_ctrl_1 = 4'b0110;
    step();
    step();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
    chk("rst_alu_src1", alu_src1, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

    // Contention right after reset: 0 first, then 1.
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1;
    chk("c0_grant", {30'd0, req_ready}, 32'd1);
    chk("c0_alu_src1", alu_src1, 32'd5);
    chk("c0_alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
    step();
    chk("c0_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("c0_result_0", rsp_result_0, 32'd8);
    chk("c1_grant", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    chk("c1_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("c1_result_1", rsp_result_1, 32'd5);
    chk("c1_op_cnt", {16'd0, op_cnt}, 32'd2);

    // Overflowing add into a slot that is not drained.
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    req_src1_0 = 32'h7FFF_FFFF; req_src2_0 = 32'd1; req_ctrl_0 = 4'b0010;
    #1;
    chk("ov_grant", {30'd0, req_ready}, 32'd1);
    step();
    chk("ov_result_0", rsp_result_0, 32'h8000_0000);
    chk("ov_flags_0", {29'd0, rsp_flags_0}, 32'd4);
    chk("ov_full_ready", {30'd0, req_ready}, 32'd0);
    step();
    chk("ov_hold_result", rsp_result_0, 32'h8000_0000);
    chk("ov_hold_flags", {29'd0, rsp_flags_0}, 32'd4);
    chk("ov_hold_cnt", {16'd0, op_cnt}, 32'd3);
    req_src1_0 = 32'd1;
    rsp_ready = 2'b01;
    #1;
    chk("drain_regrant", {30'd0, req_ready}, 32'd1);
    step();
    chk("b2b_result_0", rsp_result_0, 32'd2);
    chk("b2b_rsp_valid", {30'd0, rsp_valid}, 32'd3);
    chk("b2b_op_cnt", {16'd0, op_cnt}, 32'd4);

    // Slot 1 blocked: requester 0 wins every cycle despite round-robin.
    exp_cnt = 4;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("blk_grant", {30'd0, req_ready}, 32'd1);
      step();
      exp_cnt++;
      chk("blk_op_cnt", {16'd0, op_cnt}, exp_cnt);
      chk("blk_result_1", rsp_result_1, 32'd5);
    end
    rsp_ready = 2'b11;
    #1;
    chk("unblk_grant", {30'd0, req_ready}, 32'd2);
    step();
    exp_cnt++;
    chk("unblk_rsp_valid", {30'd0, rsp_valid}, 32'd2);

    // Continuous alternation; narrow counter saturates at 15.
    req_src1_0 = 32'h0000_F0F0; req_src2_0 = 32'h0000_FF00; req_ctrl_0 = 4'b0000;
    req_src1_1 = 32'h0000_000F; req_src2_1 = 32'h0000_00F0; req_ctrl_1 = 4'b0001;
    for (int k = 0; k < 14; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("alt_grant", {30'd0, req_ready}, {30'd0, exp_g});
      step();
      exp_cnt++;
      chk("alt_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_g});
      chk("alt_op_cnt", {16'd0, op_cnt}, exp_cnt);
      chk("sat_op_cnt", {28'd0, s_op_cnt}, (exp_cnt > 15) ? 32'd15 : exp_cnt);
      if (k % 2 == 0) chk("alt_result_0", rsp_result_0, 32'h0000_F000);
      else            chk("alt_result_1", rsp_result_1, 32'h0000_00FF);
    end

    // Fill both slots, then reset mid-cycle.
    rsp_ready = 2'b00;
    #1;
    chk("fill_grant", {30'd0, req_ready}, 32'd1);
    step();
    chk("fill_rsp_valid", {30'd0, rsp_valid}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("async_op_cnt", {16'd0, op_cnt}, 32'd0);
    chk("async_result_0", rsp_result_0, 32'd0);
    chk("async_req_ready", {30'd0, req_ready}, 32'd0);
    chk("async_alu_src2", alu_src2, 32'd0);
    #1;
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1;
    chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
    step();
    chk("post_rst_valid", {30'd0, rsp_valid}, 32'd1);
    chk("post_rst_cnt", {16'd0, op_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
